// File: rtl/score_bcd_converter.sv
`default_nettype none
// ============================================================================
// score_bcd_converter : iterative double-dabble, 14-bit score -> 4 BCD digits
// Revision: 1.0
// ============================================================================
module score_bcd_converter #(
  parameter int BIN_W   = 14,
  parameter int MAX_VAL = 9999
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [BIN_W-1:0] bin_in,
  output logic [3:0]       display_ones,
  output logic [3:0]       display_tens,
  output logic [3:0]       display_hundreds,
  output logic [3:0]       display_thousands,
  output logic             saturated,
  output logic             busy,
  output logic             done
);

  localparam int               WORK_W   = 16 + BIN_W;
  localparam int               CNT_W    = $clog2(BIN_W + 1);
  localparam logic [BIN_W-1:0] MAX_BIN  = BIN_W'(MAX_VAL);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic [CNT_W-1:0]  count;
  logic [WORK_W-1:0] work;
  logic [WORK_W-1:0] work_adj;
  logic [WORK_W-1:0] work_shifted;
  logic [15:0]       bcd_adj;
  logic [BIN_W-1:0]  clamped;
  logic              over_max;
  logic              sat_pending;
  logic              last_shift;

  assign over_max   = (bin_in > MAX_BIN);
  assign clamped    = over_max ? MAX_BIN : bin_in;
  assign last_shift = (count == LAST_CNT);

  // All four nibbles are corrected in parallel from their pre-shift values
  for (genvar i = 0; i < 4; i++) begin : g_adj
    logic [3:0] nib;
    assign nib               = work[BIN_W + 4*i +: 4];
    assign bcd_adj[4*i +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
  end

  assign work_adj     = {bcd_adj, work[BIN_W-1:0]};
  assign work_shifted = work_adj << 1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last_shift) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SHIFT);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count             <= '0;
      work              <= '0;
      sat_pending       <= 1'b0;
      display_ones      <= 4'd0;
      display_tens      <= 4'd0;
      display_hundreds  <= 4'd0;
      display_thousands <= 4'd0;
      saturated         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            work        <= {16'b0, clamped};
            sat_pending <= over_max;
            count       <= '0;
          end
        end
        SHIFT: begin
          work  <= work_shifted;
          count <= count + 1'b1;
          // Digits publish together so the renderer never sees a partial value
          if (last_shift) begin
            display_ones      <= work_shifted[BIN_W      +: 4];
            display_tens      <= work_shifted[BIN_W + 4  +: 4];
            display_hundreds  <= work_shifted[BIN_W + 8  +: 4];
            display_thousands <= work_shifted[BIN_W + 12 +: 4];
            saturated         <= sat_pending;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_score_bcd_converter.sv
`default_nettype none
// ============================================================================
// tb_score_bcd_converter : randomized self-checking bench with arithmetic model
// Revision: 1.0
// ============================================================================
module tb_score_bcd_converter;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [13:0] bin_in;
  logic [3:0]  display_ones;
  logic [3:0]  display_tens;
  logic [3:0]  display_hundreds;
  logic [3:0]  display_thousands;
  logic        saturated;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;
  logic [15:0] prev_bcd = 16'h0;
  logic        prev_sat = 1'b0;

  score_bcd_converter #(.BIN_W(14), .MAX_VAL(9999)) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .bin_in            (bin_in),
    .display_ones      (display_ones),
    .display_tens      (display_tens),
    .display_hundreds  (display_hundreds),
    .display_thousands (display_thousands),
    .saturated         (saturated),
    .busy              (busy),
    .done              (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_bcd(input int v);
    int c;
    c = (v > 9999) ? 9999 : v;
    return 16'((c / 1000) << 12 | ((c / 100) % 10) << 8 | ((c / 10) % 10) << 4 | (c % 10));
  endfunction

  function automatic logic [15:0] shown();
    return {display_thousands, display_hundreds, display_tens, display_ones};
  endfunction

  // Runs one conversion from IDLE; start is pulsed for a single cycle
  task automatic run_conv(input int v, input string tag);
    int n;
    start  = 1'b1;
    bin_in = 14'(v);
    step();
    start  = 1'b0;
    bin_in = 14'($urandom);
    n = 1;
    while (!done && n < 30) begin
      check_val({tag, "_busy"}, busy, 1);
      check_val({tag, "_hold"}, shown(), prev_bcd);
      step();
      n++;
    end
    check_val({tag, "_lat"}, n, 15);
    check_val({tag, "_digits"}, shown(), model_bcd(v));
    check_val({tag, "_sat"}, saturated, (v > 9999) ? 1 : 0);
    check_val({tag, "_busy_end"}, busy, 0);
    prev_bcd = model_bcd(v);
    prev_sat = (v > 9999);
    step();
    check_val({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    int n;
    int dones;
    reset  = 1'b1;
    start  = 1'b0;
    bin_in = '0;
    step();
    step();
    check_val("rst_digits", shown(), 0);
    check_val("rst_sat", saturated, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    reset = 1'b0;
    step();

    run_conv(0, "zero");
    run_conv(1234, "c1234");
    run_conv(9999, "c9999");
    run_conv(16383, "c16383");
    run_conv(10000, "c10000");
    run_conv(42, "c0042");

    // Start held high, bin_in disturbed mid-conversion
    start  = 1'b1;
    bin_in = 14'd507;
    step();
    dones = 0;
    for (int i = 1; i < 15; i++) begin
      if (i == 3) bin_in = 14'd0;
      if (!done) check_val("held_hold", shown(), 16'h0042);
      if (done) dones++;
      step();
    end
    if (done) dones++;
    check_val("held_done_at15", done, 1);
    check_val("held_digits", shown(), model_bcd(507));
    check_val("held_sat", saturated, 0);
    step();
    check_val("held_one_done", dones, 1);
    check_val("held_ignored_in_done", busy, 0);
    step();
    check_val("held_restart", busy, 1);
    start = 1'b0;
    prev_bcd = model_bcd(507);
    n = 1;
    while (!done && n < 30) begin
      step();
      n++;
    end
    check_val("held2_lat", n, 15);
    check_val("held2_digits", shown(), model_bcd(0));
    prev_bcd = model_bcd(0);
    step();

    // Reset in the middle of a conversion
    run_conv(3333, "pre_rst");
    start  = 1'b1;
    bin_in = 14'd8765;
    step();
    start = 1'b0;
    for (int i = 1; i < 7; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_val("midrst_digits", shown(), 0);
    check_val("midrst_sat", saturated, 0);
    check_val("midrst_busy", busy, 0);
    dones = 0;
    for (int i = 0; i < 16; i++) begin
      if (done) dones++;
      step();
    end
    check_val("midrst_no_done", dones, 0);
    prev_bcd = 16'h0;
    run_conv(100, "c0100");

    // Back-to-back: start in the DONE cycle is ignored, next cycle accepted
    start  = 1'b1;
    bin_in = 14'd2468;
    step();
    start = 1'b0;
    n = 1;
    while (!done && n < 30) begin
      step();
      n++;
    end
    check_val("b2b_lat", n, 15);
    start  = 1'b1;
    bin_in = 14'd1357;
    step();
    n++;
    check_val("b2b_ignored", busy, 0);
    step();
    n++;
    check_val("b2b_accept", busy, 1);
    check_val("b2b_spacing", n, 17);
    start = 1'b0;
    prev_bcd = model_bcd(2468);
    n = 1;
    while (!done && n < 30) begin
      step();
      n++;
    end
    check_val("b2b2_lat", n, 15);
    check_val("b2b2_digits", shown(), model_bcd(1357));
    prev_bcd = model_bcd(1357);
    step();

    // Randomized conversions with random idle gaps
    for (int k = 0; k < 16; k++) begin
      int v;
      v = (k % 4 == 0) ? int'($urandom_range(9990, 16383)) : int'($urandom_range(0, 16383));
      run_conv(v, "rand");
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
